// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM/IO bus controller shared by the store/load buffer and the fetch unit.
// Moves one byte per cycle, little-endian, one transfer at a time; completion is a 1-cycle pulse.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), has_misbranch (flush from ROB)
//   read_mem/write_mem/mem_addr/Byte_num/write_data -> out_mem_ready/out_mem_data  (load/store side)
//   if_req/if_addr -> if_ready/if_data                                             (fetch side)
//   mem_din/mem_dout/mem_a/mem_wr, io_buffer_full                                  (RAM/IO bus)
module mem_ctrl #(
   parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        has_misbranch,
   input  logic        read_mem,
   input  logic        write_mem,
   input  logic [31:0] mem_addr,
   input  logic [2:0]  Byte_num,
   input  logic [31:0] write_data,
   output logic        out_mem_ready,
   output logic [31:0] out_mem_data,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_data,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   // registered state
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_size;
   logic          r_is_fetch;
   logic [DW-1:0] r_rbuf;
   logic [DW-1:0] r_wdata;
   logic          r_ls_pend;
   logic          r_ls_wr;
   logic [AW-1:0] r_ls_addr;
   logic [CW-1:0] r_ls_size;
   logic [DW-1:0] r_ls_data;
   logic          r_mem_wr;
   logic [AW-1:0] r_mem_a;
   logic [7:0]    r_mem_dout;
   logic          r_out_mem_ready;
   logic [DW-1:0] r_out_mem_data;
   logic          r_if_ready;
   logic [DW-1:0] r_if_data;

   // next-state values
   logic [1:0]    w_state;
   logic [CW-1:0] w_cnt;
   logic [CW-1:0] w_size;
   logic          w_is_fetch;
   logic [DW-1:0] w_rbuf;
   logic [DW-1:0] w_wdata;
   logic          w_ls_pend;
   logic          w_ls_wr;
   logic [AW-1:0] w_ls_addr;
   logic [CW-1:0] w_ls_size;
   logic [DW-1:0] w_ls_data;
   logic          w_mem_wr;
   logic [AW-1:0] w_mem_a;
   logic [7:0]    w_mem_dout;
   logic          w_out_mem_ready;
   logic [DW-1:0] w_out_mem_data;
   logic          w_if_ready;
   logic [DW-1:0] w_if_data;
   logic [1:0]    w_lane;
   logic [DW-1:0] w_word;
   logic          w_io_blocked;

   assign mem_wr        = r_mem_wr;
   assign mem_a         = r_mem_a;
   assign mem_dout      = r_mem_dout;
   assign out_mem_ready = r_out_mem_ready;
   assign out_mem_data  = r_out_mem_data;
   assign if_ready      = r_if_ready;
   assign if_data       = r_if_data;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_size          <= '0;
         r_is_fetch      <= 1'b0;
         r_rbuf          <= '0;
         r_wdata         <= '0;
         r_ls_pend       <= 1'b0;
         r_ls_wr         <= 1'b0;
         r_ls_addr       <= '0;
         r_ls_size       <= '0;
         r_ls_data       <= '0;
         r_mem_wr        <= 1'b0;
         r_mem_a         <= '0;
         r_mem_dout      <= '0;
         r_out_mem_ready <= 1'b0;
         r_out_mem_data  <= '0;
         r_if_ready      <= 1'b0;
         r_if_data       <= '0;
      end else begin
         r_state         <= w_state;
         r_cnt           <= w_cnt;
         r_size          <= w_size;
         r_is_fetch      <= w_is_fetch;
         r_rbuf          <= w_rbuf;
         r_wdata         <= w_wdata;
         r_ls_pend       <= w_ls_pend;
         r_ls_wr         <= w_ls_wr;
         r_ls_addr       <= w_ls_addr;
         r_ls_size       <= w_ls_size;
         r_ls_data       <= w_ls_data;
         r_mem_wr        <= w_mem_wr;
         r_mem_a         <= w_mem_a;
         r_mem_dout      <= w_mem_dout;
         r_out_mem_ready <= w_out_mem_ready;
         r_out_mem_data  <= w_out_mem_data;
         r_if_ready      <= w_if_ready;
         r_if_data       <= w_if_data;
      end
   end

   // next-state and output logic
   always_comb begin
      w_state         = r_state;
      w_cnt           = r_cnt;
      w_size          = r_size;
      w_is_fetch      = r_is_fetch;
      w_rbuf          = r_rbuf;
      w_wdata         = r_wdata;
      w_ls_pend       = r_ls_pend;
      w_ls_wr         = r_ls_wr;
      w_ls_addr       = r_ls_addr;
      w_ls_size       = r_ls_size;
      w_ls_data       = r_ls_data;
      w_mem_wr        = r_mem_wr;
      w_mem_a         = r_mem_a;
      w_mem_dout      = r_mem_dout;
      w_out_mem_ready = r_out_mem_ready;
      w_out_mem_data  = r_out_mem_data;
      w_if_ready      = r_if_ready;
      w_if_data       = r_if_data;
      w_lane          = 2'(r_cnt - 3'd1);
      w_word          = r_rbuf;
      w_io_blocked    = 1'b0;

      // byte captured this edge lands in lane cnt-1 (cnt=0 is the address-only cycle)
      if (r_cnt != '0) begin
         w_word = r_rbuf | (DW'(mem_din) << {w_lane, 3'b000});
      end

      if (rdy) begin
         w_out_mem_ready = 1'b0;
         w_if_ready      = 1'b0;

         // LS requests latch even while busy; the buffer guarantees at most one outstanding
         if (read_mem || write_mem) begin
            w_ls_pend = 1'b1;
            w_ls_wr   = write_mem;
            w_ls_addr = mem_addr;
            w_ls_size = Byte_num;
            w_ls_data = write_data;
         end
         w_io_blocked = w_ls_wr && io_buffer_full && (w_ls_addr[17:16] == IO_ADDR_HI);

         case (r_state)
            S_IDLE: begin
               if (w_ls_pend) begin
                  if (w_ls_wr) begin
                     if (!w_io_blocked) begin
                        w_ls_pend  = 1'b0;
                        w_mem_wr   = 1'b1;
                        w_mem_a    = w_ls_addr;
                        w_mem_dout = w_ls_data[7:0];
                        w_wdata    = w_ls_data;
                        w_size     = w_ls_size;
                        w_cnt      = 3'd1;
                        w_state    = S_WRITE;
                     end
                  end else begin
                     w_ls_pend  = 1'b0;
                     w_mem_a    = w_ls_addr;
                     w_size     = w_ls_size;
                     w_is_fetch = 1'b0;
                     w_rbuf     = '0;
                     w_cnt      = '0;
                     w_state    = S_READ;
                  end
               end else if (if_req) begin
                  w_mem_a    = if_addr;
                  w_size     = 3'd4;
                  w_is_fetch = 1'b1;
                  w_rbuf     = '0;
                  w_cnt      = '0;
                  w_state    = S_READ;
               end
            end
            S_READ: begin
               w_rbuf = w_word;
               if (r_cnt == r_size) begin
                  w_cnt   = '0;
                  w_state = S_IDLE;
                  if (r_is_fetch) begin
                     // fetch abandoned by the fetch unit completes silently
                     if (if_req) begin
                        w_if_ready = 1'b1;
                        w_if_data  = w_word;
                     end
                  end else begin
                     w_out_mem_ready = 1'b1;
                     w_out_mem_data  = w_word;
                  end
               end else begin
                  w_cnt = 3'(r_cnt + 3'd1);
                  if (3'(r_cnt + 3'd1) < r_size) begin
                     w_mem_a = r_mem_a + 32'd1;
                  end
               end
            end
            S_WRITE: begin
               if (r_cnt == r_size) begin
                  w_mem_wr        = 1'b0;
                  w_out_mem_ready = 1'b1;
                  w_cnt           = '0;
                  w_state         = S_IDLE;
               end else begin
                  w_mem_a    = r_mem_a + 32'd1;
                  w_mem_dout = 8'(r_wdata >> {r_cnt[1:0], 3'b000});
                  w_cnt      = 3'(r_cnt + 3'd1);
               end
            end
            default: begin
               w_state = S_IDLE;
            end
         endcase
      end

      // flush: loads and fetches die, stores (pending or in flight) survive
      if (has_misbranch) begin
         w_if_ready = 1'b0;
         if (r_state == S_READ) begin
            w_state         = S_IDLE;
            w_mem_wr        = 1'b0;
            w_cnt           = '0;
            w_out_mem_ready = 1'b0;
            w_out_mem_data  = r_out_mem_data;
            w_if_data       = r_if_data;
         end else if ((r_state == S_IDLE) && (w_state == S_READ)) begin
            w_state = S_IDLE;
            w_mem_a = r_mem_a;
            w_cnt   = r_cnt;
            w_rbuf  = r_rbuf;
         end
         if (w_ls_pend && !w_ls_wr) begin
            w_ls_pend = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a registered byte-RAM model.
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        has_misbranch;
   logic        read_mem;
   logic        write_mem;
   logic [31:0] mem_addr;
   logic [2:0]  Byte_num;
   logic [31:0] write_data;
   logic        out_mem_ready;
   logic [31:0] out_mem_data;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_data;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   int n_checks;
   int n_errors;

   logic [31:0] wr_a [64];
   logic [7:0]  wr_d [64];
   int          wr_n;

   mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
      .read_mem(read_mem), .write_mem(write_mem), .mem_addr(mem_addr),
      .Byte_num(Byte_num), .write_data(write_data),
      .out_mem_ready(out_mem_ready), .out_mem_data(out_mem_data),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM contents: fixed word at 0x100, elsewhere low address byte xor 0x5A
   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      case (a)
         32'h100: ram_rd = 8'h11;
         32'h101: ram_rd = 8'h22;
         32'h102: ram_rd = 8'h33;
         32'h103: ram_rd = 8'h44;
         default: ram_rd = a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // RAM shares the global enable; write log records every bus write
   always @(posedge clk) begin
      if (rdy) mem_din <= ram_rd(mem_a);
      if (rst) begin
         wr_n <= 0;
      end else if (rdy && mem_wr) begin
         wr_a[wr_n[5:0]] <= mem_a;
         wr_d[wr_n[5:0]] <= mem_dout;
         wr_n <= wr_n + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; rdy = 1'b1; has_misbranch = 1'b0; read_mem = 1'b0; write_mem = 1'b0;
      mem_addr = '0; Byte_num = '0; write_data = '0; if_req = 1'b0; if_addr = '0;
      io_buffer_full = 1'b0;
      tick; tick;
      n_checks++;
      if ({mem_wr, out_mem_ready, if_ready} !== 3'b000) begin
         $display("FAIL reset_flags got %b exp 000", {mem_wr, out_mem_ready, if_ready}); n_errors++;
      end
      n_checks++;
      if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
         $display("FAIL reset_bus got a=%h d=%h exp 0/0", mem_a, mem_dout); n_errors++;
      end
      n_checks++;
      if (out_mem_data !== 32'h0 || if_data !== 32'h0) begin
         $display("FAIL reset_data got %h/%h exp 0/0", out_mem_data, if_data); n_errors++;
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_lw;
      logic [31:0] ea;
      read_mem = 1'b1; mem_addr = 32'h100; Byte_num = 3'd4;
      tick;
      read_mem = 1'b0;
      n_checks++;
      if (mem_a !== 32'h100) begin
         $display("FAIL lw_a0 got %h exp %h", mem_a, 32'h100); n_errors++;
      end
      for (int k = 1; k <= 5; k++) begin
         tick;
         ea = 32'h100 + 32'((k < 3) ? k : 3);
         n_checks++;
         if (mem_a !== ea) begin
            $display("FAIL lw_addr cyc %0d got %h exp %h", k, mem_a, ea); n_errors++;
         end
         n_checks++;
         if (out_mem_ready !== (k == 5)) begin
            $display("FAIL lw_ready cyc %0d got %b exp %b", k, out_mem_ready, (k == 5)); n_errors++;
         end
      end
      n_checks++;
      if (out_mem_data !== 32'h44332211) begin
         $display("FAIL lw_data got %h exp %h", out_mem_data, 32'h44332211); n_errors++;
      end
      tick;
      n_checks++;
      if (out_mem_ready !== 1'b0) begin
         $display("FAIL lw_pulse_width got %b exp 0", out_mem_ready); n_errors++;
      end
   endtask

   task automatic test_sh;
      int base;
      base = wr_n;
      write_mem = 1'b1; mem_addr = 32'h205; Byte_num = 3'd2; write_data = 32'h0000BEEF;
      tick;
      write_mem = 1'b0;
      n_checks++;
      if ({mem_wr, mem_a, mem_dout, out_mem_ready} !== {1'b1, 32'h205, 8'hEF, 1'b0}) begin
         $display("FAIL sh_b0 got wr=%b a=%h d=%h rdy=%b exp 1/205/ef/0", mem_wr, mem_a, mem_dout, out_mem_ready);
         n_errors++;
      end
      tick;
      n_checks++;
      if ({mem_wr, mem_a, mem_dout, out_mem_ready} !== {1'b1, 32'h206, 8'hBE, 1'b0}) begin
         $display("FAIL sh_b1 got wr=%b a=%h d=%h rdy=%b exp 1/206/be/0", mem_wr, mem_a, mem_dout, out_mem_ready);
         n_errors++;
      end
      tick;
      n_checks++;
      if ({mem_wr, out_mem_ready} !== 2'b01) begin
         $display("FAIL sh_done got wr=%b rdy=%b exp 0/1", mem_wr, out_mem_ready); n_errors++;
      end
      tick;
      n_checks++;
      if (out_mem_ready !== 1'b0 || (wr_n - base) != 2) begin
         $display("FAIL sh_count got rdy=%b writes=%0d exp 0/2", out_mem_ready, wr_n - base); n_errors++;
      end
      n_checks++;
      if (wr_a[base[5:0]] !== 32'h205 || wr_d[base[5:0]] !== 8'hEF ||
          wr_a[6'(base + 1)] !== 32'h206 || wr_d[6'(base + 1)] !== 8'hBE) begin
         $display("FAIL sh_log got %h:%h %h:%h exp 205:ef 206:be", wr_a[base[5:0]], wr_d[base[5:0]],
                  wr_a[6'(base + 1)], wr_d[6'(base + 1)]);
         n_errors++;
      end
   endtask

   task automatic test_arbitration;
      logic [31:0] ea;
      if_req = 1'b1; if_addr = 32'h0;
      read_mem = 1'b1; mem_addr = 32'h50; Byte_num = 3'd1;
      tick;
      read_mem = 1'b0;
      n_checks++;
      if (mem_a !== 32'h50) begin
         $display("FAIL arb_load_first got %h exp %h", mem_a, 32'h50); n_errors++;
      end
      tick;
      tick;
      n_checks++;
      if (out_mem_ready !== 1'b1 || out_mem_data !== 32'h0000000A || if_ready !== 1'b0) begin
         $display("FAIL arb_lb got rdy=%b data=%h if=%b exp 1/0000000a/0", out_mem_ready, out_mem_data, if_ready);
         n_errors++;
      end
      for (int k = 3; k <= 8; k++) begin
         tick;
         ea = 32'((k < 6) ? (k - 3) : 3);
         n_checks++;
         if (mem_a !== ea || out_mem_ready !== 1'b0) begin
            $display("FAIL arb_fetch_addr cyc %0d got %h/%b exp %h/0", k, mem_a, out_mem_ready, ea); n_errors++;
         end
         n_checks++;
         if (if_ready !== (k == 8)) begin
            $display("FAIL arb_if_ready cyc %0d got %b exp %b", k, if_ready, (k == 8)); n_errors++;
         end
      end
      n_checks++;
      if (if_data !== 32'h59585B5A) begin
         $display("FAIL arb_if_data got %h exp %h", if_data, 32'h59585B5A); n_errors++;
      end
      if_req = 1'b0;
      tick;
      n_checks++;
      if (if_ready !== 1'b0) begin
         $display("FAIL arb_if_width got %b exp 0", if_ready); n_errors++;
      end
   endtask

   task automatic test_io_full;
      int base;
      base = wr_n;
      io_buffer_full = 1'b1;
      write_mem = 1'b1; mem_addr = 32'h30000; Byte_num = 3'd1; write_data = 32'h0000007E;
      tick;
      write_mem = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (mem_wr !== 1'b0) begin
            $display("FAIL io_stall cyc %0d got %b exp 0", k, mem_wr); n_errors++;
         end
         if (k < 2) tick;
      end
      io_buffer_full = 1'b0;
      tick;
      n_checks++;
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h7E}) begin
         $display("FAIL io_write got wr=%b a=%h d=%h exp 1/30000/7e", mem_wr, mem_a, mem_dout); n_errors++;
      end
      tick;
      n_checks++;
      if ({mem_wr, out_mem_ready} !== 2'b01 || (wr_n - base) != 1) begin
         $display("FAIL io_done got wr=%b rdy=%b writes=%0d exp 0/1/1", mem_wr, out_mem_ready, wr_n - base);
         n_errors++;
      end
      tick;
   endtask

   task automatic test_misbranch;
      int          base;
      logic [31:0] wd;
      logic [7:0]  ed;
      read_mem = 1'b1; mem_addr = 32'h100; Byte_num = 3'd4;
      tick;
      read_mem = 1'b0;
      tick; tick;
      has_misbranch = 1'b1;
      tick;
      has_misbranch = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (out_mem_ready !== 1'b0 || mem_wr !== 1'b0) begin
            $display("FAIL mb_load_abort cyc %0d got rdy=%b wr=%b exp 0/0", k, out_mem_ready, mem_wr); n_errors++;
         end
         tick;
      end
      base = wr_n;
      wd = 32'hCAFEF00D;
      write_mem = 1'b1; mem_addr = 32'h400; Byte_num = 3'd4; write_data = wd;
      tick;
      write_mem = 1'b0;
      has_misbranch = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ed = 8'(wd >> (8 * k));
         n_checks++;
         if ({mem_wr, mem_a, mem_dout, out_mem_ready} !== {1'b1, 32'h400 + 32'(k), ed, 1'b0}) begin
            $display("FAIL mb_store_byte %0d got wr=%b a=%h d=%h rdy=%b exp 1/%h/%h/0", k, mem_wr, mem_a,
                     mem_dout, out_mem_ready, 32'h400 + 32'(k), ed);
            n_errors++;
         end
         tick;
         has_misbranch = 1'b0;
      end
      n_checks++;
      if ({mem_wr, out_mem_ready} !== 2'b01 || (wr_n - base) != 4) begin
         $display("FAIL mb_store_done got wr=%b rdy=%b writes=%0d exp 0/1/4", mem_wr, out_mem_ready, wr_n - base);
         n_errors++;
      end
      tick;
   endtask

   task automatic test_rdy_freeze;
      logic [31:0] ea;
      if_req = 1'b1; if_addr = 32'h1F0;
      tick; tick; tick;
      n_checks++;
      if (mem_a !== 32'h1F2) begin
         $display("FAIL frz_pre got %h exp %h", mem_a, 32'h1F2); n_errors++;
      end
      rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick;
         n_checks++;
         if (mem_a !== 32'h1F2 || if_ready !== 1'b0) begin
            $display("FAIL frz_hold cyc %0d got %h/%b exp 1f2/0", k, mem_a, if_ready); n_errors++;
         end
      end
      rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         ea = 32'h1F3;
         n_checks++;
         if (mem_a !== ea || if_ready !== (k == 2)) begin
            $display("FAIL frz_resume cyc %0d got %h/%b exp %h/%b", k, mem_a, if_ready, ea, (k == 2)); n_errors++;
         end
      end
      n_checks++;
      if (if_data !== 32'hA9A8ABAA) begin
         $display("FAIL frz_data got %h exp %h", if_data, 32'hA9A8ABAA); n_errors++;
      end
      if_req = 1'b0;
      tick;
   endtask

   task automatic test_if_drop;
      if_req = 1'b1; if_addr = 32'h10;
      tick; tick;
      if_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick;
         n_checks++;
         if (if_ready !== 1'b0 || out_mem_ready !== 1'b0) begin
            $display("FAIL drop_if cyc %0d got if=%b ls=%b exp 0/0", k, if_ready, out_mem_ready); n_errors++;
         end
      end
   endtask

   task automatic test_wrap;
      logic [31:0] ea;
      read_mem = 1'b1; mem_addr = 32'hFFFFFFFE; Byte_num = 3'd4;
      tick;
      read_mem = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick;
         ea = 32'hFFFFFFFE + 32'((k < 3) ? k : 3);
         n_checks++;
         if (mem_a !== ea || out_mem_ready !== (k == 5)) begin
            $display("FAIL wrap cyc %0d got %h/%b exp %h/%b", k, mem_a, out_mem_ready, ea, (k == 5)); n_errors++;
         end
      end
      n_checks++;
      if (out_mem_data !== 32'h5B5AA5A4) begin
         $display("FAIL wrap_data got %h exp %h", out_mem_data, 32'h5B5AA5A4); n_errors++;
      end
      tick;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset;
      test_lw;
      test_sh;
      test_arbitration;
      test_io_full;
      test_misbranch;
      test_rdy_freeze;
      test_if_drop;
      test_wrap;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
